// File: rtl/vol_pkg.sv
// rtl/vol_pkg.sv - shared OLED geometry, mic constants and level type for the volume bar
package vol_pkg;

    localparam int OLED_W    = 96;
    localparam int OLED_H    = 64;
    localparam int NPIX      = OLED_W * OLED_H;
    localparam int MIC_MID   = 2048;
    localparam int LVL_SHIFT = 6;

    typedef logic [4:0] level_t;

    // Exact floor(v/3) for v < 256; pixel row is (idx>>5)/3 since 96 = 32*3.
    function automatic logic [7:0] div3(input logic [7:0] v);
        return 8'(({9'd0, v} * 17'd171) >> 9);
    endfunction

endpackage

// File: rtl/volume_bar_gen_if.sv
// rtl/volume_bar_gen_if.sv - sample, control and pixel signals between driver and bar generator
interface volume_bar_gen_if;

    logic        sample_valid;
    logic [11:0] mic_sample;
    logic        freeze;
    logic [12:0] pixel_index;
    logic        enable;
    logic [4:0]  coord;
    logic [4:0]  level;

    modport master (
        output sample_valid, mic_sample, freeze, pixel_index,
        input  enable, coord, level
    );

    modport slave (
        input  sample_valid, mic_sample, freeze, pixel_index,
        output enable, coord, level
    );

endinterface

// File: rtl/peak_window.sv
// rtl/peak_window.sv - per-window peak amplitude detector emitting a 5-bit level strobe
module peak_window
    import vol_pkg::*;
#(
    parameter int WINDOW = 4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid_i,
    input  logic [11:0] mic_sample_i,
    output level_t      new_lvl_o,
    output logic        lvl_valid_o
);

    localparam int CW = $clog2(WINDOW);

    logic [CW-1:0] cnt_q;
    logic [10:0]   peak_q;
    level_t        new_lvl_q;
    logic          lvl_valid_q;

    logic [11:0]   diff;
    logic [10:0]   amp;
    logic [10:0]   peak_d;

    // Only a sample of exactly 0 reaches 2048 and needs saturating.
    always_comb begin
        diff   = (mic_sample_i >= 12'(MIC_MID)) ? (mic_sample_i - 12'(MIC_MID))
                                                : (12'(MIC_MID) - mic_sample_i);
        amp    = diff[11] ? 11'h7FF : diff[10:0];
        peak_d = (amp > peak_q) ? amp : peak_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            peak_q      <= '0;
            new_lvl_q   <= '0;
            lvl_valid_q <= 1'b0;
        end else begin
            lvl_valid_q <= 1'b0;
            if (sample_valid_i) begin
                if (cnt_q == CW'(WINDOW - 1)) begin
                    new_lvl_q   <= level_t'(peak_d >> LVL_SHIFT);
                    lvl_valid_q <= 1'b1;
                    peak_q      <= '0;
                    cnt_q       <= '0;
                end else begin
                    peak_q      <= peak_d;
                    cnt_q       <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign new_lvl_o   = new_lvl_q;
    assign lvl_valid_o = lvl_valid_q;

endmodule

// File: rtl/volume_bar_gen.sv
// rtl/volume_bar_gen.sv - decaying bar level with peak-hold marker, mapped onto OLED pixels
module volume_bar_gen
    import vol_pkg::*;
#(
    parameter int WINDOW       = 4000,
    parameter int HOLD_WINDOWS = 5,
    parameter int BAR_X0       = 40,
    parameter int BAR_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    volume_bar_gen_if.slave      bus
);

    localparam int HCW = $clog2(HOLD_WINDOWS + 1);

    level_t         new_lvl;
    logic           lvl_valid;

    level_t         disp_q, disp_d;
    level_t         hold_q, hold_d;
    logic [HCW-1:0] hcnt_q, hcnt_d;

    logic           en_q, en_d;
    logic [4:0]     coord_q, coord_d;

    logic [7:0]     row;
    logic [13:0]    x_full;
    logic [4:0]     crow;
    logic [4:0]     seg;
    logic           in_bar;
    logic           lit;

    peak_window #(.WINDOW(WINDOW)) u_peak (
        .clk            (clk),
        .reset          (reset),
        .sample_valid_i (bus.sample_valid),
        .mic_sample_i   (bus.mic_sample),
        .new_lvl_o      (new_lvl),
        .lvl_valid_o    (lvl_valid)
    );

    always_comb begin
        disp_d = disp_q;
        hold_d = hold_q;
        hcnt_d = hcnt_q;
        if (lvl_valid && !bus.freeze) begin
            if (new_lvl >= disp_q) disp_d = new_lvl;
            else                   disp_d = disp_q - 5'd1;

            if (new_lvl >= hold_q) begin
                hold_d = new_lvl;
                hcnt_d = '0;
            end else if (hcnt_q == HCW'(HOLD_WINDOWS - 1)) begin
                if (hold_q != 5'd0) hold_d = hold_q - 5'd1;
            end else begin
                hcnt_d = hcnt_q + HCW'(1);
            end

            // The marker must never sit below the bar top.
            if (hold_d < disp_d) hold_d = disp_d;
        end
    end

    always_comb begin
        row     = div3(bus.pixel_index[12:5]);
        x_full  = {1'b0, bus.pixel_index} - {row, 6'd0} - {1'b0, row, 5'd0};
        crow    = row[5:1];
        seg     = 5'd31 - crow;
        in_bar  = (bus.pixel_index < 13'(NPIX)) &&
                  (x_full >= 14'(BAR_X0)) && (x_full < 14'(BAR_X0 + BAR_W));
        lit     = (seg < disp_q) || ((hold_q != 5'd0) && (seg == hold_q - 5'd1));
        en_d    = in_bar && !row[0] && lit;
        coord_d = in_bar ? crow : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q  <= '0;
            hold_q  <= '0;
            hcnt_q  <= '0;
            en_q    <= 1'b0;
            coord_q <= '0;
        end else begin
            disp_q  <= disp_d;
            hold_q  <= hold_d;
            hcnt_q  <= hcnt_d;
            en_q    <= en_d;
            coord_q <= coord_d;
        end
    end

    assign bus.enable = en_q;
    assign bus.coord  = coord_q;
    assign bus.level  = disp_q;

endmodule

// File: tb/tb_volume_bar_gen.sv
// tb/tb_volume_bar_gen.sv - randomized self-checking bench for volume_bar_gen against a window-level model
module tb_volume_bar_gen;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    volume_bar_gen_if bus();

    volume_bar_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int m_disp, m_hold, m_hcnt, m_peak, m_cnt;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_disp = 0; m_hold = 0; m_hcnt = 0; m_peak = 0; m_cnt = 0;
    endtask

    task automatic model_window(input int lvl);
        if (lvl >= m_disp) m_disp = lvl;
        else               m_disp = m_disp - 1;
        if (lvl >= m_hold) begin
            m_hold = lvl;
            m_hcnt = 0;
        end else if (m_hcnt == 4) begin
            if (m_hold > 0) m_hold = m_hold - 1;
        end else begin
            m_hcnt = m_hcnt + 1;
        end
        if (m_hold < m_disp) m_hold = m_disp;
    endtask

    task automatic send_sample(input int v, input int gap);
        int amp;
        bus.mic_sample   = v[11:0];
        bus.sample_valid = 1'b1;
        tick;
        bus.sample_valid = 1'b0;
        amp = (v >= 2048) ? v - 2048 : 2048 - v;
        if (amp > 2047) amp = 2047;
        if (amp > m_peak) m_peak = amp;
        if (m_cnt == 3999) begin
            if (!bus.freeze) model_window(m_peak / 64);
            m_peak = 0;
            m_cnt  = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
        repeat (gap) tick;
    endtask

    task automatic send_window(input int spike, input int pos);
        for (int i = 0; i < 4000; i++) send_sample((i == pos) ? spike : 2048, 0);
    endtask

    task automatic exp_pixel(input int idx, output logic en, output logic [4:0] cd);
        int x, y, r, s;
        bit inbar;
        x = idx % 96;
        y = idx / 96;
        r = y / 2;
        s = 31 - r;
        inbar = (idx < 6144) && (x >= 40) && (x < 56);
        en = inbar && (y % 2 == 0) && ((s < m_disp) || (m_hold != 0 && s == m_hold - 1));
        cd = inbar ? 5'(r) : 5'd0;
    endtask

    task automatic probe(input int idx, output logic en, output logic [4:0] cd);
        bus.pixel_index = idx[12:0];
        tick;
        en = bus.enable;
        cd = bus.coord;
    endtask

    task automatic test_reset;
        logic e_en; logic [4:0] e_cd;
        bus.pixel_index = 13'(96 * 62 + 40);
        reset = 1'b1;
        tick;
        checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        checks++; if (bus.enable !== 1'b0) begin failures++; $display("FAIL reset_enable: got %0b want 0", bus.enable); end
        checks++; if (bus.coord !== 5'd0) begin failures++; $display("FAIL reset_coord: got %0d want 0", bus.coord); end
        reset = 1'b0;
        model_reset;
        tick;
        exp_pixel(96 * 62 + 40, e_en, e_cd);
        checks++; if (bus.enable !== e_en || bus.coord !== e_cd) begin failures++;
            $display("FAIL post_reset_pixel: got en=%0b cd=%0d want en=%0b cd=%0d", bus.enable, bus.coord, e_en, e_cd); end
    endtask

    task automatic test_silence;
        logic e_en; logic [4:0] e_cd;
        int idx;
        send_window(2048, 0);
        tick; tick;
        checks++; if (bus.level !== 5'd0 || bus.level !== m_disp[4:0]) begin failures++;
            $display("FAIL silence_level: got %0d want 0", bus.level); end
        for (int i = 0; i < 6200 + 4; i++) begin
            idx = (i < 6200) ? i : 8191 - (i - 6200);
            bus.pixel_index = idx[12:0];
            tick;
            exp_pixel(idx, e_en, e_cd);
            checks++; if (bus.enable !== e_en || bus.coord !== e_cd) begin failures++;
                $display("FAIL silence_pixel %0d: got en=%0b cd=%0d want en=%0b cd=%0d", idx, bus.enable, bus.coord, e_en, e_cd); end
        end
    endtask

    task automatic test_full_peak;
        logic en; logic [4:0] cd;
        int pos;
        int prev;
        prev = m_disp;
        pos = $urandom_range(0, 3999);
        send_window(4095, pos);
        checks++; if (bus.level !== prev[4:0]) begin failures++;
            $display("FAIL peak_level_early: got %0d want %0d", bus.level, prev); end
        tick;
        checks++; if (bus.level !== 5'd31 || bus.level !== m_disp[4:0]) begin failures++;
            $display("FAIL peak_level: got %0d want 31", bus.level); end
        probe(96 * 62 + 40, en, cd);
        checks++; if (en !== 1'b1 || cd !== 5'd31) begin failures++;
            $display("FAIL peak_bottom_pixel: got en=%0b cd=%0d want en=1 cd=31", en, cd); end
        probe(96 * 1 + 40, en, cd);
        checks++; if (en !== 1'b0 || cd !== 5'd0) begin failures++;
            $display("FAIL peak_odd_row: got en=%0b cd=%0d want en=0 cd=0", en, cd); end
    endtask

    task automatic test_decay_hold;
        logic en, e_en; logic [4:0] cd, e_cd;
        int hold_exp;
        for (int w = 0; w < 7; w++) begin
            send_window(2048, 0);
            tick; tick;
            checks++; if (bus.level !== 5'(30 - w) || bus.level !== m_disp[4:0]) begin failures++;
                $display("FAIL decay_level w%0d: got %0d want %0d", w, bus.level, 30 - w); end
            hold_exp = (w < 4) ? 31 : 34 - w;
            probe(96 * (2 * (32 - hold_exp)) + 45, en, cd);
            checks++; if (en !== 1'b1 || cd !== 5'(32 - hold_exp)) begin failures++;
                $display("FAIL hold_marker w%0d: got en=%0b cd=%0d want en=1 cd=%0d", w, en, cd, 32 - hold_exp); end
            for (int y = 0; y < 64; y++) begin
                probe(96 * y + 45, en, cd);
                exp_pixel(96 * y + 45, e_en, e_cd);
                checks++; if (en !== e_en || cd !== e_cd) begin failures++;
                    $display("FAIL decay_column w%0d y%0d: got en=%0b cd=%0d want en=%0b cd=%0d", w, y, en, cd, e_en, e_cd); end
            end
        end
    endtask

    task automatic test_attack;
        reset = 1'b1; tick; reset = 1'b0; model_reset;
        send_window(2048 + 1280, $urandom_range(0, 3999));
        tick; tick;
        checks++; if (bus.level !== 5'd20 || bus.level !== m_disp[4:0]) begin failures++;
            $display("FAIL attack_level: got %0d want 20", bus.level); end
        send_window(2048 - 640, $urandom_range(0, 3999));
        tick; tick;
        checks++; if (bus.level !== 5'd19 || bus.level !== m_disp[4:0]) begin failures++;
            $display("FAIL attack_decay: got %0d want 19", bus.level); end
    endtask

    task automatic test_freeze;
        logic en, e_en; logic [4:0] cd, e_cd;
        bus.freeze = 1'b1;
        tick;
        send_window(4095, $urandom_range(0, 3999));
        tick; tick;
        checks++; if (bus.level !== 5'd19 || bus.level !== m_disp[4:0]) begin failures++;
            $display("FAIL freeze_level: got %0d want 19", bus.level); end
        bus.freeze = 1'b0;
        tick;
        send_window(2048, 0);
        tick; tick;
        checks++; if (bus.level !== 5'd18 || bus.level !== m_disp[4:0]) begin failures++;
            $display("FAIL unfreeze_level: got %0d want 18", bus.level); end
        probe(96 * 24 + 45, en, cd);
        exp_pixel(96 * 24 + 45, e_en, e_cd);
        checks++; if (en !== e_en || cd !== e_cd || en !== 1'b1) begin failures++;
            $display("FAIL freeze_marker: got en=%0b cd=%0d want en=%0b cd=%0d", en, cd, e_en, e_cd); end
    endtask

    task automatic test_reset_mid_window;
        logic en; logic [4:0] cd;
        for (int i = 0; i < 1999; i++) send_sample(2048, 0);
        send_sample(4095, 0);
        bus.pixel_index = 13'(96 * 62 + 40);
        reset = 1'b1;
        tick;
        checks++; if (bus.level !== 5'd0 || bus.enable !== 1'b0 || bus.coord !== 5'd0) begin failures++;
            $display("FAIL midreset_outputs: got lvl=%0d en=%0b cd=%0d want 0 0 0", bus.level, bus.enable, bus.coord); end
        reset = 1'b0;
        model_reset;
        send_window(2048, 0);
        tick; tick;
        checks++; if (bus.level !== 5'd0 || bus.level !== m_disp[4:0]) begin failures++;
            $display("FAIL midreset_window: got %0d want 0", bus.level); end
        probe(96 * 62 + 40, en, cd);
        checks++; if (en !== 1'b0 || cd !== 5'd31) begin failures++;
            $display("FAIL midreset_pixel: got en=%0b cd=%0d want en=0 cd=31", en, cd); end
    endtask

    task automatic test_random;
        logic en, e_en; logic [4:0] cd, e_cd;
        int v, idx;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 99) < 3) v = $urandom_range(0, 4095);
                else                           v = 2048 + $urandom_range(0, 200) - 100;
                send_sample(v, ($urandom_range(0, 2) == 0) ? 1 : 0);
            end
            tick; tick;
            checks++; if (bus.level !== m_disp[4:0]) begin failures++;
                $display("FAIL random_level w%0d: got %0d want %0d", w, bus.level, m_disp); end
            for (int k = 0; k < 24; k++) begin
                if (k % 2 == 0) idx = $urandom_range(0, 8191);
                else            idx = 96 * $urandom_range(0, 63) + $urandom_range(36, 59);
                probe(idx, en, cd);
                exp_pixel(idx, e_en, e_cd);
                checks++; if (en !== e_en || cd !== e_cd) begin failures++;
                    $display("FAIL random_pixel %0d: got en=%0b cd=%0d want en=%0b cd=%0d", idx, en, cd, e_en, e_cd); end
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.sample_valid = 1'b0;
        bus.mic_sample   = 12'd2048;
        bus.freeze       = 1'b0;
        bus.pixel_index  = '0;
        model_reset;
        test_reset;
        test_silence;
        test_full_peak;
        test_decay_hold;
        test_attack;
        test_freeze;
        test_reset_mid_window;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
